// File: rtl/crc_encoder.sv
// Bit-serial CRC encoder: divides {data, (M-1) zeros} by G one bit per clock and holds
// {data, remainder} under a valid/ready handshake. Optional CRC_ENC_INJECT_EN adds bit-flip injection.
module crc_encoder #(
  parameter int M = 5,
  parameter int K = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [K-1:0]     data_in,
  input  logic [M-1:0]     G,
`ifdef CRC_ENC_INJECT_EN
  input  logic             inj_en,
  input  logic [$clog2(K+M-1)-1:0] inj_pos,
`endif
  output logic             busy,
  output logic             g_err,
  output logic             cw_valid,
  input  logic             cw_ready,
  output logic [K+M-2:0]   codeword,
  output logic [M-2:0]     remainder
);
  localparam int N  = K + M - 1;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]    state_reg;
  logic [K-1:0]  data_reg;
  logic [M-2:0]  g_reg;      // G[M-1] is always 1 once accepted, so only the low bits are kept
  logic [M-2:0]  rem_reg;
  logic [N-1:0]  sh_reg;
  logic [CW-1:0] cnt_reg;
  logic          g_err_reg;
  logic [N-1:0]  codeword_reg;
  logic [M-2:0]  remainder_reg;
  logic [M-2:0]  rem_next;
  logic [N-1:0]  flip_mask;

  assign rem_next = {rem_reg[M-3:0], sh_reg[N-1]} ^ (rem_reg[M-2] ? g_reg : '0);

`ifdef CRC_ENC_INJECT_EN
  localparam int PW = $clog2(N);
  logic          inj_en_reg;
  logic [PW-1:0] inj_pos_reg;

  // Positions >= N never match a bit, so no flip happens for them
  for (genvar gi = 0; gi < N; gi++) begin : g_flip
    assign flip_mask[gi] = inj_en_reg && (inj_pos_reg == PW'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inj_en_reg  <= 1'b0;
      inj_pos_reg <= '0;
    end else if (state_reg == S_IDLE && start && G[M-1]) begin
      inj_en_reg  <= inj_en;
      inj_pos_reg <= inj_pos;
    end
  end
`else
  assign flip_mask = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      data_reg      <= '0;
      g_reg         <= '0;
      rem_reg       <= '0;
      sh_reg        <= '0;
      cnt_reg       <= '0;
      g_err_reg     <= 1'b0;
      codeword_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      g_err_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (G[M-1]) begin
              data_reg  <= data_in;
              g_reg     <= G[M-2:0];
              rem_reg   <= '0;
              sh_reg    <= {data_in, {(M-1){1'b0}}};
              cnt_reg   <= '0;
              state_reg <= S_SHIFT;
            end else begin
              g_err_reg <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          rem_reg <= rem_next;
          sh_reg  <= sh_reg << 1;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(N - 1)) begin
            codeword_reg  <= {data_reg, rem_next} ^ flip_mask;
            remainder_reg <= rem_next;
            state_reg     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (cw_ready) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_reg == S_SHIFT) || (state_reg == S_HOLD);
  assign cw_valid  = (state_reg == S_HOLD);
  assign g_err     = g_err_reg;
  assign codeword  = codeword_reg;
  assign remainder = remainder_reg;
endmodule

// File: tb/tb_crc_encoder.sv
// Directed self-checking bench for crc_encoder (M=5, K=10) with a polynomial-division model.
module tb_crc_encoder;
  localparam int M = 5;
  localparam int K = 10;
  localparam int N = K + M - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [K-1:0]  data_in = '0;
  logic [M-1:0]  G = '0;
  logic          busy, g_err, cw_valid;
  logic          cw_ready = 1'b0;
  logic [N-1:0]  codeword;
  logic [M-2:0]  remainder;
`ifdef CRC_ENC_INJECT_EN
  logic          inj_en = 1'b0;
  logic [$clog2(N)-1:0] inj_pos = '0;
`endif

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_cw = '0;
  logic [M-2:0] exp_rem = '0;

  crc_encoder #(.M(M), .K(K)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .G(G),
`ifdef CRC_ENC_INJECT_EN
    .inj_en(inj_en), .inj_pos(inj_pos),
`endif
    .busy(busy), .g_err(g_err), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .codeword(codeword), .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  // Textbook long division of data*x^(M-1) by G
  function automatic logic [M-2:0] model_rem(input logic [K-1:0] d, input logic [M-1:0] g);
    logic [N-1:0] dv = {d, {(M-1){1'b0}}};
    logic [N-1:0] gx = {{(N-M){1'b0}}, g};
    for (int i = N - 1; i >= M - 1; i--)
      if (dv[i]) dv ^= gx << (i - (M - 1));
    return dv[M-2:0];
  endfunction

  always @(negedge clk) begin
    if (!reset && cw_valid) begin
      check("hold_codeword", codeword, exp_cw);
      check("hold_remainder", remainder, exp_rem);
    end
  end

  // One transaction: start, measure latency, hold hold_cycles with ready low, then handshake
  task automatic do_txn(input logic [K-1:0] d, input logic [M-1:0] g, input int hold_cycles,
                        input bit noise, input bit inj, input int pos);
    int edges;
    exp_rem = model_rem(d, g);
    exp_cw = {d, exp_rem};
    if (inj && pos < N) exp_cw[pos] = ~exp_cw[pos];
`ifdef CRC_ENC_INJECT_EN
    inj_en = inj;
    inj_pos = pos[$clog2(N)-1:0];
`endif
    start = 1'b1; data_in = d; G = g; cw_ready = 1'b0;
    @(negedge clk);
    edges = 1;
    start = 1'b0;
    while (!cw_valid && edges < 40) begin
      if (noise) begin
        start = 1'b1;
        data_in = K'($urandom);
        G = {1'b1, (M-1)'($urandom)};
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    check("latency", edges - 1, N);
    for (int i = 0; i < hold_cycles; i++) begin
      check("hold_busy", {busy, cw_valid}, 2'b11);
      if (noise) begin
        start = ~start;
        data_in = K'($urandom);
        G = {1'b1, (M-1)'($urandom)};
      end
      @(negedge clk);
    end
    cw_ready = 1'b1;
    start = noise;
    @(negedge clk);
    check("after_handshake", {busy, cw_valid}, 2'b00);
    cw_ready = 1'b0;
    start = 1'b0;
    $display("txn data=%b G=%b remainder=%b codeword=%b hold=%0d", d, g, remainder, codeword, hold_cycles);
  endtask

  initial begin
    // Model pinned to hand-computed values
    check("lit_rem_a", model_rem(10'b1101011011, 5'b10011), 4'b1110);
    check("lit_cw_a", {10'b1101011011, model_rem(10'b1101011011, 5'b10011)}, 14'b11010110111110);
    check("lit_rem_b", model_rem(10'b0000000001, 5'b10011), 4'b0011);
    check("lit_rem_c", model_rem(10'b1000000000, 5'b10011), 4'b1101);
    check("lit_rem_zero", model_rem(10'b0, 5'b10011), 4'b0000);

    @(negedge clk); @(negedge clk);
    check("reset_outputs", {busy, g_err, cw_valid, codeword, remainder}, '0);
    reset = 1'b0;
    @(negedge clk);

    do_txn(10'b1101011011, 5'b10011, 0, 0, 0, 0);
    do_txn(10'b0000000001, 5'b10011, 0, 0, 0, 0);
    do_txn(10'b0000000000, 5'b10011, 0, 0, 0, 0);
    do_txn(10'b1000000000, 5'b10011, 20, 1, 0, 0);
    do_txn(10'b1111111111, 5'b11101, 3, 1, 0, 0);
    do_txn(10'b1010010110, 5'b10101, 1, 0, 0, 0);

    // Rejected generator
    start = 1'b1; data_in = 10'b1101011011; G = 5'b00011;
    @(negedge clk);
    start = 1'b0;
    check("g_err_pulse", {g_err, busy, cw_valid}, 3'b100);
    @(negedge clk);
    check("g_err_clear", {g_err, busy, cw_valid}, 3'b000);
    @(negedge clk);
    check("g_err_idle", {g_err, busy, cw_valid}, 3'b000);

    // Reset in the middle of SHIFT
    start = 1'b1; data_in = 10'b1101011011; G = 5'b10011;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_shift_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset_outputs", {busy, g_err, cw_valid, codeword, remainder}, '0);
    do_txn(10'b0110110001, 5'b10011, 2, 0, 0, 0);

`ifdef CRC_ENC_INJECT_EN
    do_txn(10'b1101011011, 5'b10011, 0, 0, 1, 0);
    check("inj_cw_lit", exp_cw, 14'b11010110111111);
    do_txn(10'b1101011011, 5'b10011, 0, 0, 1, 13);
    do_txn(10'b1101011011, 5'b10011, 0, 0, 1, 15);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
